// File: rtl/breath_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : breath_sequencer
// Brief    : Breathing-LED ramp sequencer (hold-low, rise, hold-high, fall)
//            with a free-running PWM output stage.
//            Optional macro BREATH_GAMMA_EN: squared-level duty with one extra
//            pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
module breath_sequencer #(
  parameter int BITS       = 8,
  parameter int DIV_BITS   = 16,
  parameter int HOLD_STEPS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [DIV_BITS-1:0] step_div,
  output logic [BITS-1:0]     level,
  output logic                pwm,
  output logic [1:0]          phase,
  output logic                cycle_done
);

  localparam logic [1:0] S_HOLD_LOW  = 2'd0;
  localparam logic [1:0] S_RISE      = 2'd1;
  localparam logic [1:0] S_HOLD_HIGH = 2'd2;
  localparam logic [1:0] S_FALL      = 2'd3;

  localparam logic [BITS-1:0]     LVL_ONE   = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [BITS-1:0]     LVL_MAX   = {BITS{1'b1}};
  localparam logic [DIV_BITS-1:0] DIV_ONE   = {{(DIV_BITS-1){1'b0}}, 1'b1};
  localparam logic [7:0]          HOLD_LAST = 8'(HOLD_STEPS - 1);

  logic [DIV_BITS-1:0] presc_q, presc_d;
  logic                tick;
  logic [7:0]          hold_q, hold_d;
  logic [BITS-1:0]     level_q, level_d;
  logic [1:0]          phase_q, phase_d;
  logic                done_q, done_d;
  logic [BITS-1:0]     pwm_cnt_q;
  logic                pwm_q, pwm_d;
  logic [BITS-1:0]     duty;

  // The >= compare lets a lowered step_div take effect immediately.
  always_comb begin
    tick    = enable && (presc_q >= step_div);
    presc_d = presc_q;
    if (tick) begin
      presc_d = '0;
    end else if (enable) begin
      presc_d = presc_q + DIV_ONE;
    end
  end

  always_comb begin
    hold_d  = hold_q;
    level_d = level_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    if (tick) begin
      case (phase_q)
        S_HOLD_LOW, S_HOLD_HIGH: begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = 8'd0;
            phase_d = (phase_q == S_HOLD_LOW) ? S_RISE : S_FALL;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        S_RISE: begin
          level_d = level_q + LVL_ONE;
          if (level_q == LVL_MAX - LVL_ONE) phase_d = S_HOLD_HIGH;
        end
        S_FALL: begin
          level_d = level_q - LVL_ONE;
          if (level_q == LVL_ONE) begin
            phase_d = S_HOLD_LOW;
            done_d  = 1'b1;
          end
        end
        default: phase_d = S_HOLD_LOW;
      endcase
    end
  end

`ifdef BREATH_GAMMA_EN
  logic [2*BITS-1:0] level_sq;
  logic [BITS-1:0]   duty_q, duty_d;

  // Full scale is forced so the brightest step still reaches max duty.
  always_comb begin
    level_sq = {{BITS{1'b0}}, level_q} * {{BITS{1'b0}}, level_q};
    duty_d   = (level_q == LVL_MAX) ? LVL_MAX : BITS'(level_sq >> BITS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty = duty_q;
`else
  assign duty = level_q;
`endif

  assign pwm_d = (pwm_cnt_q < duty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      hold_q    <= 8'd0;
      level_q   <= '0;
      phase_q   <= S_HOLD_LOW;
      done_q    <= 1'b0;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      phase_q   <= phase_d;
      done_q    <= done_d;
      pwm_cnt_q <= pwm_cnt_q + LVL_ONE;
      pwm_q     <= pwm_d;
    end
  end

  assign level      = level_q;
  assign pwm        = pwm_q;
  assign phase      = phase_q;
  assign cycle_done = done_q;

endmodule
`default_nettype wire
